// File: rtl/shift_pkg.sv
// shift_pkg: opcode constants and decode for the shift issue stage
package shift_pkg;
  localparam int SH_OP_W = 3;
  localparam logic [SH_OP_W-1:0] SH_LSR = 3'd0;
  localparam logic [SH_OP_W-1:0] SH_LSL = 3'd1;
  localparam logic [SH_OP_W-1:0] SH_ASR = 3'd2;
  localparam logic [SH_OP_W-1:0] SH_ASL = 3'd3;
  localparam logic [SH_OP_W-1:0] SH_ROR = 3'd4;
  localparam logic [SH_OP_W-1:0] SH_ROL = 3'd5;
  typedef struct packed {
    logic rotate;
    logic left;
    logic arith;
    logic illegal;
  } sh_ctl_t;
  function automatic sh_ctl_t sh_decode(input logic [SH_OP_W-1:0] op);
    sh_ctl_t c;
    c.rotate  = (op == SH_ROR) | (op == SH_ROL);
    c.left    = (op == SH_LSL) | (op == SH_ASL) | (op == SH_ROL);
    c.arith   = (op == SH_ASR) | (op == SH_ASL);
    c.illegal = op > SH_ROL;
    return c;
  endfunction
endpackage

// File: rtl/bshift_32.sv
// bshift_32: combinational 32-bit barrel shifter, count 0..31
module bshift_32 (
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic        rotate,
  input  logic        left,
  input  logic        arith,
  output logic [31:0] q,
  output logic        ov,
  output logic        z
);
  logic [31:0] sl, sr, rl, rr, ext;
  logic [30:0] diff;
  logic [5:0]  rb;
  always_comb begin
    ext  = {32{arith & a[31]}};
    sl   = a << b;
    sr   = (a >> b) | (ext & ~(32'hFFFF_FFFF >> b));
    rb   = 6'd32 - {1'b0, b};
    rl   = sl | (a >> rb);
    rr   = (a >> b) | (a << rb);
    diff = a[30:0] ^ {31{a[31]}};
    // arithmetic left keeps the sign bit; overflow when any dropped bit differs from it
    q    = rotate ? (left ? rl : rr) : left ? (arith ? {a[31], sl[30:0]} : sl) : sr;
    ov   = ~rotate & left & arith & |(diff >> (5'd31 - b));
    z    = ~|q;
  end
endmodule

// File: rtl/shift_issue_32.sv
// shift_issue_32: two-stage shift execution unit around bshift_32
module shift_issue_32 import shift_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SH_OP_W-1:0] in_op,
  input  logic [31:0]        in_a,
  input  logic [7:0]         in_cnt,
  input  logic [3:0]         in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_q,
  output logic               out_ov,
  output logic               out_z,
  output logic               out_err,
  output logic [3:0]         out_tag
);
  logic        s1_valid, s1_big, s2_load, accept, over;
  sh_ctl_t     s1_ctl;
  logic [31:0] s1_a, bs_q, nq;
  logic [4:0]  s1_b;
  logic [3:0]  s1_tag;
  logic        bs_ov, bs_z, nov, nz;
  assign s2_load  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_load;
  assign accept   = in_valid & in_ready & ~flush;
  bshift_32 u_bshift (
    .a(s1_a), .b(s1_b), .rotate(s1_ctl.rotate), .left(s1_ctl.left), .arith(s1_ctl.arith),
    .q(bs_q), .ov(bs_ov), .z(bs_z)
  );
  // counts of 32 and above are outside bshift_32's range and resolved here
  always_comb begin
    over = s1_ctl.illegal | (s1_big & ~s1_ctl.rotate);
    nq   = s1_ctl.illegal ? s1_a :
           (~s1_big | s1_ctl.rotate) ? bs_q :
           ~s1_ctl.arith ? 32'h0 :
           s1_ctl.left ? {s1_a[31], 31'b0} : {32{s1_a[31]}};
    nov  = s1_ctl.illegal ? 1'b0 :
           over ? (s1_ctl.arith & s1_ctl.left & |(s1_a[30:0] ^ {31{s1_a[31]}})) : bs_ov;
    nz   = over ? ~|nq : bs_z;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s1_valid <= 1'b0;
    else s1_valid <= ~flush & (accept | (s1_valid & ~s2_load));
  always_ff @(posedge clk)
    if (accept) begin
      s1_a   <= in_a;
      s1_b   <= in_cnt[4:0];
      s1_big <= |in_cnt[7:5];
      s1_ctl <= sh_decode(in_op);
      s1_tag <= in_tag;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_ov    <= 1'b0;
      out_z     <= 1'b0;
      out_err   <= 1'b0;
      out_tag   <= '0;
    end else begin
      out_valid <= ~flush & (s2_load ? s1_valid : out_valid);
      if (s2_load & s1_valid) begin
        out_q   <= nq;
        out_ov  <= nov;
        out_z   <= nz;
        out_err <= s1_ctl.illegal;
        out_tag <= s1_tag;
      end
    end
endmodule
